pipe_trace_monitor: RTL and testbench
=====================================

PIPE_TRACE_MONITOR -- requirements
Module: pipe_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PC and writeback data.
REQ-002 SHALL have parameter TRACE_DEPTH, default 16, trace FIFO entries; power of two, 2..256.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of every event counter.
REQ-004 SHALL have parameter WDOG_CYCLES, default 1024, consecutive unchanged-PC cycles that declare a hang; 1..2^CNT_WIDTH-1.
REQ-005 SHALL have parameter SKIP_R0, default 1, when 1 writes to register 0 are not traced or counted.
REQ-006 SHALL have the port Clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have the port Reset, input, 1, asynchronous, active-high; clears all state.
REQ-008 SHALL have the port Enable, input, 1, starts monitoring (IDLE->RUN).
REQ-009 SHALL have the port Clear, input, 1, synchronous; zeroes counters, empties FIFO, clears Overflow and Hung, returns to IDLE.
REQ-010 SHALL have the port PC, input, DATA_WIDTH, current fetch PC.
REQ-011 SHALL have the port PCWrite, input, 1, hazard unit PC enable; 0 = stall cycle.
REQ-012 SHALL have the port Flush, input, 1, hazard unit IF/ID flush.
REQ-013 SHALL have the port RegWrite, input, 1, writeback stage register write strobe.
REQ-014 SHALL have the port WriteRegister, input, 5, writeback destination.
REQ-015 SHALL have the port WriteData, input, DATA_WIDTH, writeback value.
REQ-016 SHALL have the port TraceRd, input, 1, pop FIFO head.
REQ-017 SHALL have the port TraceValid, output, 1, FIFO non-empty.
REQ-018 SHALL have the port TraceData, output, 2*DATA_WIDTH+5, head entry {PC, WriteRegister, WriteData}, first-word fall-through.
REQ-019 SHALL have the port CycleCount, StallCount, FlushCount, RetireCount, DropCount, outputs, CNT_WIDTH each.
REQ-020 SHALL have the port Overflow, output, 1, sticky, set when an entry is dropped.
REQ-021 SHALL have the port Hung, output, 1, high in HUNG state.

Function
REQ-022 SHALL implement states IDLE, RUN, HUNG; IDLE->RUN when Enable=1; RUN->HUNG when the watchdog reaches WDOG_CYCLES; HUNG exits only on Clear or Reset; Clear takes priority over every other transition.
REQ-023 SHALL, in RUN only, increment CycleCount every cycle, StallCount when PCWrite=0, FlushCount when Flush=1, both in one cycle when both hold.
REQ-024 SHALL define a retire event as RegWrite=1 and not (SKIP_R0=1 and WriteRegister=0), qualified only in RUN.
REQ-025 SHALL on a retire event increment RetireCount and push {PC, WriteRegister, WriteData} sampled that cycle; if FIFO full and no pop that cycle, drop the entry, increment DropCount, set Overflow.
REQ-026 SHALL allow simultaneous push and pop when full: pop head, push new entry, no drop, occupancy unchanged.
REQ-027 SHALL ignore TraceRd when empty; pops remain allowed in IDLE and HUNG so software can drain.
REQ-028 SHALL wrap read/write pointers modulo TRACE_DEPTH; full/empty distinguished by an extra pointer bit.
REQ-029 SHALL saturate every counter at 2^CNT_WIDTH-1 (no wrap).
REQ-030 SHALL keep a watchdog counter: in RUN, reset to 0 when PC differs from previous-cycle PC, else increment; entering HUNG on the cycle it would reach WDOG_CYCLES; in IDLE the counter holds 0.
REQ-031 SHALL freeze all counters and stop pushes in HUNG and IDLE.
REQ-032 SHALL present TraceData of the new head on the cycle after a pop; TraceData undefined-but-stable when TraceValid=0.

Reset
REQ-033 SHALL on Reset=1 asynchronously enter IDLE, zero all counters, watchdog, previous-PC register and FIFO pointers, drive TraceValid=0, Overflow=0, Hung=0.
REQ-034 SHALL treat Reset asserted mid-push or mid-pop as discarding the operation; no partial entry visible after release.

Verification
REQ-035 SHALL cover: Enable=1, 3 retires (r8<=5, r0<=7, r9<=-1) with SKIP_R0=1 -> RetireCount=2, two FIFO entries in order, r9 entry WriteData=0xFFFFFFFF.
REQ-036 SHALL cover: TRACE_DEPTH=4, 6 retires no pops -> 4 entries kept (first four), DropCount=2, Overflow=1; then full with push+pop same cycle -> DropCount stays 2.
REQ-037 SHALL cover: 10 RUN cycles with PCWrite=0 on 3 and Flush=1 on 2 (one overlapping) -> CycleCount=10, StallCount=3, FlushCount=2.
REQ-038 SHALL cover: WDOG_CYCLES=8, PC held constant -> Hung=1 at 8th unchanged cycle, counters frozen; Clear -> IDLE, all zero.
REQ-039 SHALL cover: CNT_WIDTH=4, 20 RUN cycles -> CycleCount=15 saturated.
REQ-040 SHALL cover: Reset asserted between clock edges with FIFO at 3 entries -> TraceValid=0 immediately, all outputs zero before next edge.

Source files
------------

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace monitor: event counters, retire trace FIFO and PC-hang watchdog.
// Snoops hazard and writeback signals; software drains the FIFO via TraceRd.
module pipe_trace_monitor #(
    parameter int DATA_WIDTH  = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int WDOG_CYCLES = 1024,
    parameter int SKIP_R0     = 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic                      Clear,
    input  logic [DATA_WIDTH-1:0]     PC,
    input  logic                      PCWrite,
    input  logic                      Flush,
    input  logic                      RegWrite,
    input  logic [4:0]                WriteRegister,
    input  logic [DATA_WIDTH-1:0]     WriteData,
    input  logic                      TraceRd,
    output logic                      TraceValid,
    output logic [2*DATA_WIDTH+4:0]   TraceData,
    output logic [CNT_WIDTH-1:0]      CycleCount,
    output logic [CNT_WIDTH-1:0]      StallCount,
    output logic [CNT_WIDTH-1:0]      FlushCount,
    output logic [CNT_WIDTH-1:0]      RetireCount,
    output logic [CNT_WIDTH-1:0]      DropCount,
    output logic                      Overflow,
    output logic                      Hung
);

    localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int EW = 2*DATA_WIDTH+5;
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;
    localparam logic [CNT_WIDTH-1:0] WDOG_LIM = CNT_WIDTH'(WDOG_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HUNG
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0]    stall_q, stall_d;
    logic [CNT_WIDTH-1:0]    flush_q, flush_d;
    logic [CNT_WIDTH-1:0]    retire_q, retire_d;
    logic [CNT_WIDTH-1:0]    drop_q, drop_d;
    logic [CNT_WIDTH-1:0]    wdog_q, wdog_d;
    logic [DATA_WIDTH-1:0]   prev_pc_q, prev_pc_d;
    logic [PW:0]             rd_ptr_q, rd_ptr_d;
    logic [PW:0]             wr_ptr_q, wr_ptr_d;
    logic                    ovf_q, ovf_d;

    logic [EW-1:0]           mem [TRACE_DEPTH];

    logic                    empty, full, in_run, pop, retire;
    logic                    push, drop, pc_same, wdog_hit;
    logic [CNT_WIDTH-1:0]    wdog_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty    = (rd_ptr_q == wr_ptr_q);
    assign full     = (rd_ptr_q[PW] != wr_ptr_q[PW]) &&
                      (rd_ptr_q[PW-1:0] == wr_ptr_q[PW-1:0]);
    assign in_run   = (state_q == S_RUN);
    assign pop      = TraceRd && !empty && !Clear;
    assign retire   = in_run && !Clear && RegWrite &&
                      !((SKIP_R0 != 0) && (WriteRegister == 5'd0));
    assign push     = retire && (!full || pop);
    assign drop     = retire && full && !pop;
    assign pc_same  = (PC == prev_pc_q);
    assign wdog_inc = wdog_q + 1'b1;
    assign wdog_hit = in_run && pc_same && (wdog_inc == WDOG_LIM);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        retire_d  = retire_q;
        drop_d    = drop_q;
        wdog_d    = wdog_q;
        prev_pc_d = PC;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        ovf_d     = ovf_q;
        if (Clear) begin
            state_d  = S_IDLE;
            cyc_d    = '0;
            stall_d  = '0;
            flush_d  = '0;
            retire_d = '0;
            drop_d   = '0;
            wdog_d   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    wdog_d = '0;
                    if (Enable) state_d = S_RUN;
                end
                S_RUN: begin
                    cyc_d = sat_inc(cyc_q);
                    if (!PCWrite) stall_d = sat_inc(stall_q);
                    if (Flush)    flush_d = sat_inc(flush_q);
                    wdog_d = pc_same ? wdog_inc : '0;
                    if (wdog_hit) state_d = S_HUNG;
                end
                S_HUNG: begin
                end
                default: state_d = S_IDLE;
            endcase
            if (retire) retire_d = sat_inc(retire_q);
            if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
            if (drop) begin
                drop_d = sat_inc(drop_q);
                ovf_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            retire_q  <= '0;
            drop_q    <= '0;
            wdog_q    <= '0;
            prev_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            retire_q  <= retire_d;
            drop_q    <= drop_d;
            wdog_q    <= wdog_d;
            prev_pc_q <= prev_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: pointers alone decide which entries are visible.
    always_ff @(posedge Clk) begin
        if (push && !Reset) mem[wr_ptr_q[PW-1:0]] <= {PC, WriteRegister, WriteData};
    end

    assign TraceValid  = !empty;
    assign TraceData   = empty ? '0 : mem[rd_ptr_q[PW-1:0]];
    assign CycleCount  = cyc_q;
    assign StallCount  = stall_q;
    assign FlushCount  = flush_q;
    assign RetireCount = retire_q;
    assign DropCount   = drop_q;
    assign Overflow    = ovf_q;
    assign Hung        = (state_q == S_HUNG);

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Bench for pipe_trace_monitor: directed scenarios plus random traffic,
// checked against a queue-based model; trace pops verified by a monitor.
module tb_pipe_trace_monitor;

    localparam int DEPTH = 4;
    localparam int WDOG  = 8;

    logic        Clk = 1'b0;
    logic        Reset, Enable, Clear, PCWrite, Flush, RegWrite, TraceRd;
    logic [31:0] PC, WriteData;
    logic [4:0]  WriteRegister;

    logic        tv, ovf, hung;
    logic [68:0] td;
    logic [7:0]  cyc, stl, fls, ret, drp;
    logic        tv4, ovf4, hung4;
    logic [68:0] td4;
    logic [3:0]  cyc4, stl4, fls4, ret4, drp4;

    int errors = 0;
    int checks = 0;

    typedef enum {M_IDLE, M_RUN, M_HUNG} mode_t;
    mode_t       m_mode;
    longint      m_cyc, m_stl, m_fls, m_ret, m_drp;
    bit          m_ovf;
    int          m_occ, m_same;
    logic [31:0] m_prev;
    logic [68:0] exp_q[$];

    always #5 Clk = ~Clk;

    pipe_trace_monitor #(
        .DATA_WIDTH(32), .TRACE_DEPTH(DEPTH), .CNT_WIDTH(8),
        .WDOG_CYCLES(WDOG), .SKIP_R0(1)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clear(Clear),
        .PC(PC), .PCWrite(PCWrite), .Flush(Flush), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .TraceRd(TraceRd), .TraceValid(tv), .TraceData(td),
        .CycleCount(cyc), .StallCount(stl), .FlushCount(fls),
        .RetireCount(ret), .DropCount(drp), .Overflow(ovf), .Hung(hung)
    );

    pipe_trace_monitor #(
        .DATA_WIDTH(32), .TRACE_DEPTH(DEPTH), .CNT_WIDTH(4),
        .WDOG_CYCLES(WDOG), .SKIP_R0(1)
    ) u_sat (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clear(Clear),
        .PC(PC), .PCWrite(PCWrite), .Flush(Flush), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .TraceRd(TraceRd), .TraceValid(tv4), .TraceData(td4),
        .CycleCount(cyc4), .StallCount(stl4), .FlushCount(fls4),
        .RetireCount(ret4), .DropCount(drp4), .Overflow(ovf4), .Hung(hung4)
    );

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return 69'(v > m ? m : v);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0; m_drp = 0;
        m_ovf = 0; m_occ = 0; m_same = 0; m_prev = '0;
        exp_q.delete();
    endtask

    // Model one clock edge from the inputs currently applied.
    task automatic model_step();
        bit pop;
        if (Clear) begin
            model_reset();
            m_prev = PC;
            return;
        end
        pop = TraceRd && (m_occ > 0);
        case (m_mode)
            M_IDLE: begin
                m_same = 0;
                if (Enable) m_mode = M_RUN;
            end
            M_RUN: begin
                m_cyc++;
                if (!PCWrite) m_stl++;
                if (Flush) m_fls++;
                if (RegWrite && WriteRegister != 5'd0) begin
                    m_ret++;
                    if (m_occ == DEPTH && !pop) begin
                        m_drp++;
                        m_ovf = 1;
                    end else begin
                        exp_q.push_back({PC, WriteRegister, WriteData});
                        m_occ++;
                    end
                end
                if (PC == m_prev) begin
                    m_same++;
                    if (m_same == WDOG) m_mode = M_HUNG;
                end else begin
                    m_same = 0;
                end
            end
            default: ;
        endcase
        if (pop) m_occ--;
        m_prev = PC;
    endtask

    task automatic check_all();
        chk("valid",    69'(tv),    69'(m_occ > 0));
        chk("cycle",    69'(cyc),   sat(m_cyc, 8));
        chk("stall",    69'(stl),   sat(m_stl, 8));
        chk("flush",    69'(fls),   sat(m_fls, 8));
        chk("retire",   69'(ret),   sat(m_ret, 8));
        chk("drop",     69'(drp),   sat(m_drp, 8));
        chk("overflow", 69'(ovf),   69'(m_ovf));
        chk("hung",     69'(hung),  69'(m_mode == M_HUNG));
        chk("cycle4",   69'(cyc4),  sat(m_cyc, 4));
        chk("stall4",   69'(stl4),  sat(m_stl, 4));
        chk("flush4",   69'(fls4),  sat(m_fls, 4));
        chk("retire4",  69'(ret4),  sat(m_ret, 4));
        chk("drop4",    69'(drp4),  sat(m_drp, 4));
        chk("hung4",    69'(hung4), 69'(m_mode == M_HUNG));
    endtask

    task automatic drive(input bit en, input bit clr, input logic [31:0] pc,
                         input bit pcw, input bit fl, input bit rw,
                         input logic [4:0] wr, input logic [31:0] wd, input bit rd);
        Enable = en; Clear = clr; PC = pc; PCWrite = pcw; Flush = fl;
        RegWrite = rw; WriteRegister = wr; WriteData = wd; TraceRd = rd;
        model_step();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    // Scoreboard monitor: every accepted pop is compared with the oldest expected entry.
    always @(negedge Clk) begin
        if (!Reset && !Clear && TraceRd && tv) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL trace_pop: got %0h expected no entry", td);
            end else begin
                chk("trace_data", td, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] pcv;
        bit          hold;

        Reset = 1'b1; Enable = 0; Clear = 0; PC = '0; PCWrite = 1; Flush = 0;
        RegWrite = 0; WriteRegister = '0; WriteData = '0; TraceRd = 0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check_all();
        chk("reset_data", td, 69'd0);

        // Retires with r0 skipped; r9 gets all ones.
        drive(1, 0, 32'h1000, 1, 0, 0, 5'd0, 32'd0, 0);
        drive(0, 0, 32'h1004, 1, 0, 1, 5'd8, 32'd5, 0);
        drive(0, 0, 32'h1008, 1, 0, 1, 5'd0, 32'd7, 0);
        drive(0, 0, 32'h100c, 1, 0, 1, 5'd9, 32'hFFFF_FFFF, 0);
        chk("r0_retire_cnt", 69'(ret), 69'd2);
        chk("r8_head", td, {32'h1004, 5'd8, 32'd5});
        drive(0, 0, 32'h1010, 1, 0, 0, 5'd0, 32'd0, 1);
        chk("r9_head", td, {32'h100c, 5'd9, 32'hFFFF_FFFF});
        drive(0, 0, 32'h1014, 1, 0, 0, 5'd0, 32'd0, 1);

        // Stall/flush accounting over ten RUN cycles.
        drive(0, 1, 32'h0, 1, 0, 0, 5'd0, 32'd0, 0);
        drive(1, 0, 32'h0, 1, 0, 0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 10; i++)
            drive(0, 0, 32'h100 + 32'(4*i), !(i == 1 || i == 4 || i == 7),
                  (i == 4 || i == 8), 0, 5'd0, 32'd0, 0);
        chk("ten_cycles", 69'(cyc), 69'd10);
        chk("ten_stalls", 69'(stl), 69'd3);
        chk("ten_flushes", 69'(fls), 69'd2);

        // Overflow: six retires into four slots, then push+pop while full.
        drive(0, 1, 32'h0, 1, 0, 0, 5'd0, 32'd0, 0);
        drive(1, 0, 32'h0, 1, 0, 0, 5'd0, 32'd0, 0);
        for (int i = 1; i <= 6; i++)
            drive(0, 0, 32'h2000 + 32'(4*i), 1, 0, 1, 5'(i), 32'(i * 11), 0);
        chk("drop_two", 69'(drp), 69'd2);
        chk("ovf_set", 69'(ovf), 69'd1);
        drive(0, 0, 32'h2100, 1, 0, 1, 5'd7, 32'd77, 1);
        chk("drop_full_pushpop", 69'(drp), 69'd2);
        for (int i = 0; i < 4; i++)
            drive(0, 0, 32'h2200 + 32'(4*i), 1, 0, 0, 5'd0, 32'd0, 1);
        chk("drained", 69'(tv), 69'd0);

        // Watchdog: PC constant from the enable cycle on.
        drive(0, 1, 32'h0, 1, 0, 0, 5'd0, 32'd0, 0);
        drive(1, 0, 32'h200, 1, 0, 0, 5'd0, 32'd0, 0);
        repeat (7) drive(0, 0, 32'h200, 1, 0, 0, 5'd0, 32'd0, 0);
        chk("hung_before", 69'(hung), 69'd0);
        drive(0, 0, 32'h200, 1, 0, 0, 5'd0, 32'd0, 0);
        chk("hung_at_8", 69'(hung), 69'd1);
        repeat (3) drive(0, 0, 32'h204, 0, 1, 1, 5'd3, 32'd1, 0);
        chk("hung_frozen", 69'(cyc), 69'd8);
        drive(0, 1, 32'h208, 1, 0, 0, 5'd0, 32'd0, 0);
        chk("clear_cycle", 69'(cyc), 69'd0);
        chk("clear_hung", 69'(hung), 69'd0);

        // 4-bit counters saturate.
        drive(1, 0, 32'h300, 1, 0, 0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 20; i++)
            drive(0, 0, 32'h304 + 32'(4*i), 1, 0, 0, 5'd0, 32'd0, 0);
        chk("sat_cycle4", 69'(cyc4), 69'd15);
        chk("cycle20", 69'(cyc), 69'd20);

        // Random traffic.
        pcv = 32'h4000;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 16 == 0) hold = ($urandom_range(0, 99) < 30);
            if (!hold) pcv = $urandom;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0, pcv,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset between edges with three entries queued.
        drive(0, 1, 32'h0, 1, 0, 0, 5'd0, 32'd0, 0);
        drive(1, 0, 32'h500, 1, 0, 0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 32'h504 + 32'(4*i), 1, 0, 1, 5'(i + 1), 32'(i), 0);
        chk("three_queued", 69'(tv), 69'd1);
        RegWrite = 1; WriteRegister = 5'd4; TraceRd = 1;
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_valid", 69'(tv), 69'd0);
        chk("async_data", td, 69'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        RegWrite = 0; TraceRd = 0;
        m_prev = '0;
        check_all();
        drive(0, 0, 32'h600, 1, 0, 0, 5'd0, 32'd0, 1);
        chk("after_reset_empty", 69'(tv), 69'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
